// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Input conditioner for a raw board input (push-button or switch). The input
// is brought into the clk domain through a two-flop synchroniser and then
// debounced. A new level reaches `out` only after it has been seen steadily
// for STABLE_CYCLES consecutive synchronised cycles. Optional one-cycle edge
// pulses mark each change of `out`.
//
// Parameters:
//   STABLE_CYCLES  consecutive stable cycles needed to commit a new level
//                  (1 .. 2**CNT_W-1)
//   CNT_W          stability counter width
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   in     in   raw asynchronous input, may bounce or glitch
//   out    out  debounced, synchronised level (registered)
//   rise   out  one-cycle pulse in the first cycle `out` shows 1
//   fall   out  one-cycle pulse in the first cycle `out` shows 0
//
// Configuration macro:
//   DEBOUNCE_SYNC_EDGE_EN  defined   -> rise/fall are registered pulses
//                          undefined -> rise/fall are tied to 0, no flops
// -----------------------------------------------------------------------------
module debounce_sync #(
   parameter int STABLE_CYCLES = 1000,
   parameter int CNT_W         = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall
);

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s1;
   logic             s2;
   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             go_high;
   logic             go_low;
   logic             out_next;

   // Two-flop synchroniser; only s2 is used past this point.
   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge value of its neighbour; with = the chain would collapse into
   // one flop and the synchroniser would be lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= in;
         s2 <= s1;
      end
   end

   // State register, stability counter and registered output level.
   // NOTE: every register here is reset, including the counter, so a reset
   // in the middle of a wait discards any partial count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOW;
         cnt   <= '0;
         out   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         out   <= out_next;
      end
   end

   // Next-state logic. go_high/go_low flag the commit transitions, which are
   // the only moments `out` is allowed to change.
   // NOTE: all outputs of this block get a default first so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      go_high    = 1'b0;
      go_low     = 1'b0;

      unique case (state)
         LOW: begin
            if (s2) begin
               if (STABLE_CYCLES == 1) begin
                  state_next = HIGH;
                  cnt_next   = '0;
                  go_high    = 1'b1;
               end else begin
                  state_next = WAIT_HIGH;
                  cnt_next   = CNT_ONE;
               end
            end
         end

         WAIT_HIGH: begin
            if (!s2) begin
               // Bounce: drop all credit and go back to the settled level.
               state_next = LOW;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = HIGH;
               cnt_next   = '0;
               go_high    = 1'b1;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end

         HIGH: begin
            if (!s2) begin
               if (STABLE_CYCLES == 1) begin
                  state_next = LOW;
                  cnt_next   = '0;
                  go_low     = 1'b1;
               end else begin
                  state_next = WAIT_LOW;
                  cnt_next   = CNT_ONE;
               end
            end
         end

         WAIT_LOW: begin
            if (s2) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = LOW;
               cnt_next   = '0;
               go_low     = 1'b1;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end

         default: begin
            state_next = LOW;
            cnt_next   = '0;
         end
      endcase

      out_next = out;
      if (go_high) begin
         out_next = 1'b1;
      end else if (go_low) begin
         out_next = 1'b0;
      end
   end

`ifdef DEBOUNCE_SYNC_EDGE_EN
   // Pulses are registered from the same commit flags as `out`, so they
   // appear in exactly the cycle `out` first shows its new value. A commit
   // is always followed by a non-commit cycle, so pulses never repeat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= go_high;
         fall <= go_low;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//
// Directed self-checking bench for debounce_sync with STABLE_CYCLES = 4.
// Expected values are hand-derived: a level applied before edge E1 reaches
// `out` (and the matching pulse) at edge E6. When DEBOUNCE_SYNC_EDGE_EN is
// not defined, rise/fall are expected to stay 0 in every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debounce_sync;

   localparam int STABLE = 4;
   localparam int LAT    = STABLE + 2;

`ifdef DEBOUNCE_SYNC_EDGE_EN
   localparam logic EDGE_EN = 1'b1;
`else
   localparam logic EDGE_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic in;
   logic out;
   logic rise;
   logic fall;

   int checks = 0;
   int errors = 0;

   debounce_sync #(
      .STABLE_CYCLES(STABLE),
      .CNT_W        (16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (in),
      .out  (out),
      .rise (rise),
      .fall (fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge, then compare all three outputs 1 ns later.
   task automatic edge_chk(input string tag, input logic e_out,
                           input logic e_rise, input logic e_fall);
      @(posedge clk);
      #1;
      check({tag, ".out"},  out,  e_out);
      check({tag, ".rise"}, rise, e_rise & EDGE_EN);
      check({tag, ".fall"}, fall, e_fall & EDGE_EN);
   endtask

   // Apply a new level between edges, then check edges 1..LAT+1 after it.
   task automatic step_chk(input string tag, input logic lvl);
      @(negedge clk);
      in = lvl;
      for (int e = 1; e <= LAT + 1; e++) begin
         edge_chk($sformatf("%s.e%0d", tag, e),
                  (e >= LAT) ? lvl : ~lvl,
                  (e == LAT) &&  lvl,
                  (e == LAT) && !lvl);
      end
   endtask

   initial begin
      // Reset held with in = 1: outputs stay 0.
      rst_n = 1'b0;
      in    = 1'b1;
      #1;
      check("rst.out0", out, 1'b0);
      for (int i = 0; i < 3; i++) begin
         edge_chk($sformatf("rst.hold%0d", i), 1'b0, 1'b0, 1'b0);
      end

      // Release: out rises through the normal path, 6 edges later.
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= LAT + 1; e++) begin
         edge_chk($sformatf("rel.e%0d", e), e >= LAT, e == LAT, 1'b0);
      end

      // Clean steps: 1 -> 0 then 0 -> 1.
      step_chk("fall", 1'b0);
      step_chk("rise", 1'b1);
      step_chk("fall2", 1'b0);

      // Bounce: 1,1,0,0,... for 20 cycles, then settle at 0.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in = ((i / 2) % 2) == 0;
         edge_chk($sformatf("bounce.c%0d", i), 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         edge_chk($sformatf("bounce.settle%0d", i), 1'b0, 1'b0, 1'b0);
      end

      // Glitch restart: 1 for 3 cycles, 0 for 1, then 1 held.
      @(negedge clk);
      in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge_chk($sformatf("glitch.hi%0d", i), 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      in = 1'b0;
      edge_chk("glitch.lo", 1'b0, 1'b0, 1'b0);
      step_chk("glitch.final", 1'b1);

      // Return to LOW.
      step_chk("fall3", 1'b0);

      // Mid-wait reset: in = 1, reset asserted inside WAIT_HIGH's 3rd cycle.
      @(negedge clk);
      in = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         edge_chk($sformatf("mid.e%0d", e), 1'b0, 1'b0, 1'b0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("mid.rst.out",  out,  1'b0);
      check("mid.rst.rise", rise, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= LAT + 1; e++) begin
         edge_chk($sformatf("mid.rel.e%0d", e), e >= LAT, e == LAT, 1'b0);
      end

      // Asynchronous reset while out = 1: clears before any clock edge.
      edge_chk("async.pre", 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async.out",  out,  1'b0);
      check("async.rise", rise, 1'b0);
      check("async.fall", fall, 1'b0);
      @(negedge clk);
      in    = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         edge_chk($sformatf("async.after%0d", i), 1'b0, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
